// File: rtl/unshift_two_pkg.sv
// Shared constants and state encoding for the dibit-to-byte deserializer.
package unshift_two_pkg;

    localparam int BYTE_W          = 8;
    localparam int DIBIT_W         = 2;
    localparam int NUM_PAIRS       = BYTE_W / DIBIT_W;
    localparam int DEF_TIMEOUT_CYC = 64;

    // IDLE is all-zero; S1..S3 are one-hot and double as "pairs held" markers.
    typedef enum logic [3:0] {
        IDLE = 4'b0000,
        S1   = 4'b0001,
        S2   = 4'b0010,
        S3   = 4'b0100
    } state_t;

endpackage

// File: rtl/unshift_two_gap_timer.sv
// Idle-gap counter: counts enabled cycles since the last clear and saturates
// at TIMEOUT_CYC, where `expired` stays high until the next clear.
module gap_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/unshift_two.sv
// Reassembles four LSB-first dibits into a byte with resync and gap timeout.
// Optional UNSHIFT_TWO_STATS_EN adds byte_cnt / err_cnt statistics outputs.
module unshift_two
    import unshift_two_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIBIT_W-1:0]  dibit_in,
    input  logic                dibit_valid,
    input  logic                frame_start,
    output logic [BYTE_W-1:0]   data_out,
    output logic                data_valid,
    output logic                frame_err,
    output logic                busy
`ifdef UNSHIFT_TWO_STATS_EN
    ,
    output logic [15:0]         byte_cnt,
    output logic [7:0]          err_cnt
`endif
);

    state_t                 state_reg, state_next;
    logic [BYTE_W-1:0]      data_out_reg, data_out_next;
    logic                   data_valid_reg, data_valid_next;
    logic                   frame_err_reg, frame_err_next;
    logic [NUM_PAIRS-2:0]   pair_we;
    logic                   pair_clr;
    logic [DIBIT_W-1:0]     pair_reg [NUM_PAIRS-1];
    logic                   accept;
    logic                   timer_expired;

    // A dibit counts as accepted when it starts a byte or extends a partial one.
    assign accept = dibit_valid && (frame_start || (state_reg != IDLE));

    gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || (state_reg == IDLE)),
        .enable  (!dibit_valid),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Held pairs 0..2; pair 3 goes straight from dibit_in into data_out.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PAIRS - 1; gi++) begin : g_pair
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pair_reg[gi] <= '0;
                end else if (pair_we[gi]) begin
                    pair_reg[gi] <= dibit_in;
                end else if (pair_clr) begin
                    pair_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        pair_we         = '0;
        pair_clr        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dibit_valid && frame_start) begin
                    pair_we[0] = 1'b1;
                    state_next = S1;
                end
            end
            S1, S2, S3: begin
                if (dibit_valid && frame_start) begin
                    // Resync: drop the partial byte, new dibit becomes pair 0.
                    frame_err_next = 1'b1;
                    pair_we[0]     = 1'b1;
                    pair_clr       = 1'b1;
                    state_next     = S1;
                end else if (dibit_valid) begin
                    case (state_reg)
                        S1: begin
                            pair_we[1] = 1'b1;
                            state_next = S2;
                        end
                        S2: begin
                            pair_we[2] = 1'b1;
                            state_next = S3;
                        end
                        default: begin
                            data_out_next   = {dibit_in, pair_reg[2], pair_reg[1], pair_reg[0]};
                            data_valid_next = 1'b1;
                            pair_clr        = 1'b1;
                            state_next      = IDLE;
                        end
                    endcase
                end else if (timer_expired) begin
                    frame_err_next = 1'b1;
                    pair_clr       = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                pair_clr   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

`ifdef UNSHIFT_TWO_STATS_EN
    logic [15:0] byte_cnt_reg;
    logic [7:0]  err_cnt_reg;

    // Byte count wraps; error count sticks at its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (data_valid_next) begin
                byte_cnt_reg <= byte_cnt_reg + 16'd1;
            end
            if (frame_err_next && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign byte_cnt = byte_cnt_reg;
    assign err_cnt  = err_cnt_reg;
`endif

endmodule

// File: tb/tb_unshift_two.sv
// Directed bench for unshift_two: byte assembly, gaps, resync, timeout,
// back-to-back throughput and mid-byte reset.
module tb_unshift_two;

    logic       clk;
    logic       rst;
    logic [1:0] dibit_in;
    logic       dibit_valid;
    logic       frame_start;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UNSHIFT_TWO_STATS_EN
    logic [15:0] byte_cnt;
    logic [7:0]  err_cnt;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    unshift_two #(
        .TIMEOUT_CYC (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dibit_in    (dibit_in),
        .dibit_valid (dibit_valid),
        .frame_start (frame_start),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy)
`ifdef UNSHIFT_TWO_STATS_EN
        ,
        .byte_cnt    (byte_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one dibit for one clock; outputs afterwards reflect that edge.
    task automatic send(input logic [1:0] d, input logic fs);
        dibit_in    = d;
        dibit_valid = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        dibit_valid = 1'b0;
        frame_start = 1'b0;
        dibit_in    = 2'b00;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (data_out !== 8'h00) begin miss_cnt++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        vec_cnt++;
        if (data_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        vec_cnt++;
        if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        vec_cnt++;
        if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_byte_b4();
        send(2'b00, 1'b1);
        send(2'b01, 1'b0);
        send(2'b11, 1'b0);
        vec_cnt++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL b4_partial busy=%b dv=%b exp busy=1 dv=0", busy, data_valid);
        end
        send(2'b10, 1'b0);
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'hB4) begin
            miss_cnt++; $display("FAIL b4_byte dv=%b data=%h exp dv=1 data=b4", data_valid, data_out);
        end
        vec_cnt++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            miss_cnt++; $display("FAIL b4_flags fe=%b busy=%b exp 0 0", frame_err, busy);
        end
        idle();
        vec_cnt++;
        if (data_valid !== 1'b0 || data_out !== 8'hB4) begin
            miss_cnt++; $display("FAIL b4_hold dv=%b data=%h exp dv=0 data=b4", data_valid, data_out);
        end
        $display("test_byte_b4: byte=%h", data_out);
    endtask

    task automatic test_gapped_5a();
        logic [1:0] pairs [4];
        logic       fe_seen;
        logic       dv_early;
        pairs[0] = 2'b10; pairs[1] = 2'b10; pairs[2] = 2'b01; pairs[3] = 2'b01;
        fe_seen  = 1'b0;
        dv_early = 1'b0;
        for (int p = 0; p < 4; p++) begin
            send(pairs[p], (p == 0));
            if (frame_err) fe_seen = 1'b1;
            if (p < 3) begin
                if (data_valid) dv_early = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    idle();
                    if (frame_err) fe_seen = 1'b1;
                    if (data_valid) dv_early = 1'b1;
                end
            end
        end
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'h5A) begin
            miss_cnt++; $display("FAIL gap_byte dv=%b data=%h exp dv=1 data=5a", data_valid, data_out);
        end
        vec_cnt++;
        if (fe_seen !== 1'b0 || dv_early !== 1'b0) begin
            miss_cnt++; $display("FAIL gap_flags fe_seen=%b early_dv=%b exp 0 0", fe_seen, dv_early);
        end
        idle();
        $display("test_gapped_5a: byte=%h", data_out);
    endtask

    task automatic test_resync();
        send(2'b11, 1'b1);
        send(2'b11, 1'b0);
        send(2'b01, 1'b1);
        vec_cnt++;
        if (frame_err !== 1'b1 || busy !== 1'b1 || data_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL resync_err fe=%b busy=%b dv=%b exp 1 1 0", frame_err, busy, data_valid);
        end
        send(2'b00, 1'b0);
        vec_cnt++;
        if (frame_err !== 1'b0) begin
            miss_cnt++; $display("FAIL resync_pulse_len fe=%b exp 0", frame_err);
        end
        send(2'b00, 1'b0);
        send(2'b00, 1'b0);
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'h01) begin
            miss_cnt++; $display("FAIL resync_byte dv=%b data=%h exp dv=1 data=01", data_valid, data_out);
        end
        idle();
        $display("test_resync: byte=%h", data_out);
    endtask

    task automatic test_timeout();
        logic fe_early;
        fe_early = 1'b0;
        send(2'b11, 1'b1);
        send(2'b11, 1'b0);
        for (int k = 0; k < 64; k++) begin
            idle();
            if (frame_err) fe_early = 1'b1;
        end
        vec_cnt++;
        if (fe_early !== 1'b0 || busy !== 1'b1) begin
            miss_cnt++; $display("FAIL timeout_early fe_seen=%b busy=%b exp 0 1", fe_early, busy);
        end
        idle();
        vec_cnt++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL timeout_fire fe=%b busy=%b dv=%b exp 1 0 0", frame_err, busy, data_valid);
        end
        vec_cnt++;
        if (data_out !== 8'h01) begin
            miss_cnt++; $display("FAIL timeout_hold data=%h exp 01", data_out);
        end
        send(2'b10, 1'b0);
        vec_cnt++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || data_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL stray_dibit busy=%b fe=%b dv=%b exp 0 0 0", busy, frame_err, data_valid);
        end
        idle();
        $display("test_timeout: data held=%h", data_out);
    endtask

    task automatic test_timeout_boundary();
        logic fe_seen;
        fe_seen = 1'b0;
        send(2'b11, 1'b1);
        for (int k = 0; k < 64; k++) begin
            idle();
            if (frame_err) fe_seen = 1'b1;
        end
        send(2'b00, 1'b0);
        if (frame_err) fe_seen = 1'b1;
        send(2'b00, 1'b0);
        send(2'b00, 1'b0);
        if (frame_err) fe_seen = 1'b1;
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'h03 || fe_seen !== 1'b0) begin
            miss_cnt++; $display("FAIL timeout_edge dv=%b data=%h fe_seen=%b exp 1 03 0", data_valid, data_out, fe_seen);
        end
        idle();
        $display("test_timeout_boundary: byte=%h", data_out);
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [12];
        logic [7:0] exp_bytes [3];
        seq[0] = 2'b00; seq[1] = 2'b00; seq[2]  = 2'b00; seq[3]  = 2'b00;
        seq[4] = 2'b11; seq[5] = 2'b11; seq[6]  = 2'b11; seq[7]  = 2'b11;
        seq[8] = 2'b11; seq[9] = 2'b00; seq[10] = 2'b00; seq[11] = 2'b11;
        exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'hC3;
        for (int i = 0; i < 12; i++) begin
            send(seq[i], ((i % 4) == 0));
            vec_cnt++;
            if ((i % 4) == 3) begin
                if (data_valid !== 1'b1 || data_out !== exp_bytes[i / 4]) begin
                    miss_cnt++; $display("FAIL b2b_byte%0d dv=%b data=%h exp dv=1 data=%h", i / 4, data_valid, data_out, exp_bytes[i / 4]);
                end else begin
                    $display("test_back_to_back: byte%0d=%h", i / 4, data_out);
                end
            end else begin
                if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
                    miss_cnt++; $display("FAIL b2b_step%0d dv=%b fe=%b exp 0 0", i, data_valid, frame_err);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_byte();
        logic fe_seen;
        fe_seen = 1'b0;
        send(2'b10, 1'b1);
        send(2'b01, 1'b0);
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            miss_cnt++; $display("FAIL mid_reset data=%h dv=%b fe=%b busy=%b exp 00 0 0 0", data_out, data_valid, frame_err, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        if (frame_err) fe_seen = 1'b1;
        send(2'b10, 1'b1);
        if (frame_err) fe_seen = 1'b1;
        send(2'b11, 1'b0);
        send(2'b01, 1'b0);
        send(2'b00, 1'b0);
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'h1E || fe_seen !== 1'b0) begin
            miss_cnt++; $display("FAIL post_reset_byte dv=%b data=%h fe_seen=%b exp 1 1e 0", data_valid, data_out, fe_seen);
        end
`ifdef UNSHIFT_TWO_STATS_EN
        vec_cnt++;
        if (byte_cnt !== 16'd1 || err_cnt !== 8'd0) begin
            miss_cnt++; $display("FAIL stats byte_cnt=%0d err_cnt=%0d exp 1 0", byte_cnt, err_cnt);
        end
`endif
        idle();
        $display("test_reset_mid_byte: byte=%h", data_out);
    endtask

    initial begin
        rst         = 1'b1;
        dibit_in    = 2'b00;
        dibit_valid = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        idle();
        test_byte_b4();
        test_gapped_5a();
        test_resync();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
